// File: rtl/c0_result_fifo.sv
// First-word-fall-through result buffer behind top_c0: registered storage,
// occupancy count, synchronous flush and a sticky overflow flag.
module c0_result_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Handshake: a transfer happens on an edge where valid and ready are both
  // high. in_ready comes only from registered count, so a pop in the same
  // cycle never frees a slot for a write to a full FIFO.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid && !w_full;
  assign w_pop   = out_ready && !w_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      if (in_valid && w_full) r_overflow <= 1'b1;
    end
  end

  // Storage is never reset; stale entries are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && w_push) r_mem[r_wr_ptr] <= in_data;
  end

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_c0_result_fifo.sv
// Directed bench for c0_result_fifo: ordering, full/overflow, streaming with
// wrap, flush, mid-stream reset and popping while empty.
module tb_c0_result_fifo;

  localparam int WIDTH = 12;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             overflow;

  int n_tests;
  int n_fail;
  logic [WIDTH-1:0] exp_q[$];

  c0_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(d);
    step();
    in_valid = 1'b0;
  endtask

  // Pop the head and compare it against the expected queue.
  task automatic pop_check(input string name);
    logic [WIDTH-1:0] e;
    e = exp_q.pop_front();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== e) begin
      n_fail++;
      $display("FAIL %s: out_valid=%b out_data=%h, required 1 / %h", name, out_valid, out_data, e);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic check_cnt(input string name, input logic [CW-1:0] e);
    n_tests++;
    if (count !== e) begin
      n_fail++;
      $display("FAIL %s: count=%0d, required %0d", name, count, e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    n_tests++;
    if ({in_ready, out_valid, out_data, count, overflow} !== {1'b1, 1'b0, 12'h000, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h count=%0d overflow=%b, required 1 0 000 0 0",
               in_ready, out_valid, out_data, count, overflow);
    end
  endtask

  task automatic test_order();
    push(12'h001); push(12'h002); push(12'h003);
    check_cnt("order_count3", 3'd3);
    n_tests++;
    if (out_data !== 12'h001) begin
      n_fail++;
      $display("FAIL order_head: out_data=%h, required 001", out_data);
    end
    for (int i = 0; i < 3; i++) pop_check("order_pop");
    check_cnt("order_count0", 3'd0);
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 12'h000) begin
      n_fail++;
      $display("FAIL order_empty: out_valid=%b out_data=%h, required 0 / 000", out_valid, out_data);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) push(12'hA00 + 12'(i));
    check_cnt("ovf_full", 3'd4);
    n_tests++;
    if (in_ready !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_full_flags: in_ready=%b overflow=%b, required 0 / 0", in_ready, overflow);
    end
    in_valid = 1'b1; in_data = 12'hBBB;
    step();
    in_valid = 1'b0;
    check_cnt("ovf_count", 3'd4);
    n_tests++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_flag: overflow=%b, required 1", overflow);
    end
    // Pop while full does not admit a simultaneous write.
    in_valid = 1'b1; in_data = 12'hCCC;
    pop_check("ovf_pop_full");
    in_valid = 1'b0;
    check_cnt("ovf_pop_full_count", 3'd3);
    for (int i = 0; i < 3; i++) pop_check("ovf_drain");
    n_tests++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL ovf_drained: out_valid=%b count=%0d, required 0 / 0", out_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] e;
    push(12'h0F0); push(12'h0F1);
    check_cnt("b2b_pre", 3'd2);
    for (int k = 0; k < 10; k++) begin
      e = exp_q.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== e || count !== 3'd2) begin
        n_fail++;
        $display("FAIL b2b_stream[%0d]: out_data=%h count=%0d, required %h / 2", k, out_data, count, e);
      end
      in_valid = 1'b1; in_data = 12'h100 + 12'(k); out_ready = 1'b1;
      exp_q.push_back(12'h100 + 12'(k));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check_cnt("b2b_post", 3'd2);
    pop_check("b2b_drain"); pop_check("b2b_drain");
  endtask

  task automatic test_flush();
    push(12'h301); push(12'h302); push(12'h303);
    check_cnt("flush_pre", 3'd3);
    flush = 1'b1; in_valid = 1'b1; in_data = 12'h777; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    n_tests++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 12'h000 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL flush: count=%0d out_valid=%b out_data=%h overflow=%b, required 0 0 000 1",
               count, out_valid, out_data, overflow);
    end
    push(12'h555);
    check_cnt("flush_push_count", 3'd1);
    pop_check("flush_push_data");
    check_cnt("flush_after_pop", 3'd0);
  endtask

  task automatic test_reset_midstream();
    push(12'h401); push(12'h402);
    check_cnt("rst_mid_pre", 3'd2);
    rst_n = 1'b0; in_valid = 1'b1; in_data = 12'h4FF; out_ready = 1'b1;
    step();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    n_tests++;
    if ({in_ready, out_valid, out_data, count, overflow} !== {1'b1, 1'b0, 12'h000, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid: in_ready=%b out_valid=%b out_data=%h count=%0d overflow=%b, required 1 0 000 0 0",
               in_ready, out_valid, out_data, count, overflow);
    end
  endtask

  task automatic test_empty_pop();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++;
      if (count !== 3'd0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL empty_pop[%0d]: count=%0d out_valid=%b, required 0 / 0", i, count, out_valid);
      end
    end
    in_valid = 1'b1; in_data = 12'hFFF;
    exp_q.push_back(12'hFFF);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check_cnt("empty_push_count", 3'd1);
    pop_check("empty_push_data");
    check_cnt("empty_final", 3'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_order();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    test_empty_pop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/c0_result_fifo.md
# c0_result_fifo

Buffers the 12-bit result word produced by the `top_c0` combinational network so that a downstream consumer with back-pressure can read it. It sits directly downstream of `top_c0`: its `in_data` is driven by `top_c0.o`. The block implements a first-word-fall-through FIFO with a valid/ready output handshake, an occupancy count, a synchronous flush and a sticky overflow flag.

## Interface
- `WIDTH`, default 12: data word width; matches `top_c0.o`.
- `DEPTH`, default 4: number of entries; must be a power of two and ≥ 2.
- `CW`, default $clog2(DEPTH+1) = 3: width of `count`.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `flush` input 1: synchronous clear of contents; does not clear `overflow`.
- `in_valid` input 1: the value on `in_data` is to be written this cycle.
- `in_data` input WIDTH: the word to write; connected to `top_c0.o`.
- `in_ready` output 1: high when the FIFO is not full (`count != DEPTH`).
- `out_valid` output 1: high when the FIFO is not empty.
- `out_data` output WIDTH: the head entry; drives 0 when empty.
- `out_ready` input 1: the consumer takes the head word this cycle.
- `count` output CW: occupancy, 0..DEPTH.
- `overflow` output 1: sticky; set by a write attempted while full.

## Operation
- Storage: `DEPTH` × `WIDTH` register array, a write pointer and a read pointer, each log2(DEPTH) bits and wrapping modulo DEPTH, plus a `count` register.
- Push: occurs when `in_valid && in_ready`. The word is written at the write pointer, and the write pointer increments.
- Pop: occurs when `out_valid && out_ready`. The read pointer increments.
- Count update:
  - push only: `count + 1`.
  - pop only: `count − 1`.
  - push and pop together: unchanged, and both pointers advance.
- Full (`count == DEPTH`):
  - `in_ready` is 0.
  - If `in_valid` = 1, the word is dropped and `overflow` is set to 1 on the next edge.
  - A pop in the same cycle does not admit the write. `in_ready` depends only on registered state, with no combinational path from `out_ready`.
- Empty (`count == 0`):
  - `out_valid` = 0 and `out_data` = 0.
  - `out_ready` is ignored and the read pointer is held.
- Flush, when `rst_n` = 1 and `flush` = 1:
  - Pointers and `count` go to 0.
  - Any push or pop in that cycle is discarded.
  - `overflow` is unchanged.
- Reset, when `rst_n` = 0 at an edge:
  - Pointers, `count` and `overflow` go to 0.
  - Array contents need not be cleared.
  - Reset has priority over `flush` and over any handshake.
- Order is strictly first-in first-out. No word is duplicated or reordered across pointer wrap.
- `overflow` is cleared only by reset.

## Timing
- Outputs after reset: `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `count` = 0, `overflow` = 0.
- Latency: a word pushed at edge N is visible on `out_data` with `out_valid` = 1 after edge N. This is one cycle, first-word fall-through.
- `out_data` is a mux of registered state (head entry gated by not-empty), so it is stable for the whole cycle.
- `count`, `in_ready`, `out_valid` and `overflow` change only on the clock edge.
- Sustained throughput is one word per cycle when `in_valid` and `out_ready` are both held high with `count` ≥ 1.
- Reset asserted mid-stream: on the first edge with `rst_n` = 0, all held data is lost and the outputs take their reset values.

## Test plan
- Reset, then push 0x001, 0x002, 0x003 on consecutive cycles with `out_ready` = 0:
  - `count` = 3 and `out_data` = 0x001.
  - Then pop three times: 0x001, 0x002, 0x003 in order, `count` = 0 and `out_valid` = 0.
- Fill with 0xA00..0xA03, then drive `in_valid` with 0xBBB:
  - `in_ready` = 0, `overflow` = 1 from the next cycle, and `count` stays 4.
  - Draining yields 0xA00..0xA03 only.
- Hold `count` = 2, then assert `in_valid` and `out_ready` for 10 cycles with data 0x100+k:
  - `count` stays 2.
  - Outputs appear in push order with pointers wrapping twice.
- With `count` = 3 and `overflow` = 1, assert `flush` together with `in_valid`:
  - Next cycle `count` = 0, `out_valid` = 0, `overflow` = 1.
  - A push of 0x555 then appears alone.
- With 2 entries held, pull `rst_n` low for one cycle while `in_valid` = `out_ready` = 1:
  - After the edge, `count` = 0, `overflow` = 0, `out_data` = 0 and `in_ready` = 1.
- Pop with `out_ready` = 1 while empty for 5 cycles, then push 0xFFF:
  - `count` never underflows.
  - 0xFFF appears one cycle later with `count` = 1.
